// File: rtl/instr_realigner_pkg.sv
// Shared types and helpers for the RVC fetch realigner and its consumers.
package instr_realigner_pkg;

   // Low two bits of an uncompressed (32-bit or wider) RISC-V encoding
   localparam logic [1:0] RVC_UNCOMPR = 2'b11;

   // Depth of the halfword queue: one leftover halfword plus one full fetch word
   localparam int HW_DEPTH = 3;

   // One buffered halfword and the fetch fault flag of the word it came from
   typedef struct packed {
      logic [15:0] hw;
      logic        err;
   } halfword_t;

   // Realigner run state; HALT is entered after a faulting instruction is handed off
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } rstate_t;

   // A halfword starts a compressed instruction unless its low bits are 2'b11
   function automatic logic is_compr(input logic [15:0] hw);
      return hw[1:0] != RVC_UNCOMPR;
   endfunction

endpackage

// File: rtl/instr_hw_fifo.sv
// Three-entry shifting halfword queue.
// Entry 0 is always the oldest halfword; a pop of one or two entries shifts the
// survivors to the front and any pushed halfwords land directly behind them in
// the same cycle. Callers guarantee no overflow and no underflow.
module instr_hw_fifo
   import instr_realigner_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic [1:0] pop_n,
   input  logic [1:0] push_n,
   input  halfword_t  push_lo,
   input  halfword_t  push_hi,
   output halfword_t  head0,
   output halfword_t  head1,
   output logic [1:0] count
);

   halfword_t [HW_DEPTH-1:0] entries;
   halfword_t [HW_DEPTH-1:0] next_entries;
   logic [1:0]               remain;
   logic [1:0]               next_count;

   // Bounded read of a queue slot; any out-of-range index falls on the last slot
   function automatic halfword_t pick(input halfword_t [HW_DEPTH-1:0] arr,
                                      input logic [1:0] idx);
      case (idx)
         2'd0:    return arr[0];
         2'd1:    return arr[1];
         default: return arr[2];
      endcase
   endfunction

   // Build the next queue image: survivors shifted forward, then the pushed halfwords
   always_comb begin
      remain       = count - pop_n;
      next_count   = remain + push_n;
      next_entries = entries;
      for (int i = 0; i < HW_DEPTH; i++) begin
         if (2'(i) < remain) begin
            next_entries[i] = pick(entries, 2'(i) + pop_n);
         end else if ((2'(i) == remain) && (push_n != 2'd0)) begin
            next_entries[i] = push_lo;
         end else if ((2'(i) == remain + 2'd1) && (push_n == 2'd2)) begin
            next_entries[i] = push_hi;
         end
      end
   end

   // Register the queue; a redirect empties it without touching the data slots
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count   <= 2'd0;
         entries <= '0;
      end else if (clear) begin
         count   <= 2'd0;
      end else begin
         count   <= next_count;
         entries <= next_entries;
      end
   end

   assign head0 = entries[0];
   assign head1 = entries[1];

endmodule

// File: rtl/instr_realigner.sv
// Fetch-side RVC realigner.
// Splits word-aligned fetch words into halfwords, reassembles 16/32-bit
// instructions (including ones straddling a word boundary) and hands one raw
// instruction per handshake, with its PC, to the decode side. Redirects may
// target the upper halfword of a word; fetch faults stop the stream until the
// next redirect.
module instr_realigner
   import instr_realigner_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic [PC_W-1:0] i_flush_pc,
   input  logic            i_fetch_valid,
   output logic            o_fetch_ready,
   input  logic [31:0]     i_fetch_data,
   input  logic [PC_W-1:0] i_fetch_pc,
   input  logic            i_fetch_err,
   output logic            o_instr_valid,
   input  logic            i_instr_ready,
   output logic [31:0]     o_instr,
   output logic [PC_W-1:0] o_instr_pc,
   output logic            o_instr_is_compr,
   output logic            o_instr_err
);

   rstate_t         state;
   logic            skip;
   logic [PC_W-1:0] head_pc;

   halfword_t       head0;
   halfword_t       head1;
   logic [1:0]      count;

   logic            run_ok;
   logic            compressed;
   logic            fetch_fire;
   logic            instr_fire;
   logic [1:0]      pop_n;
   logic [1:0]      push_n;
   halfword_t       push_lo;
   halfword_t       push_hi;

   instr_hw_fifo u_fifo (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .clear   (i_flush),
      .pop_n   (pop_n),
      .push_n  (push_n),
      .push_lo (push_lo),
      .push_hi (push_hi),
      .head0   (head0),
      .head1   (head1),
      .count   (count)
   );

   // Both handshakes are suppressed while in reset, halted or redirecting
   assign run_ok     = i_rst_n && (state == ST_RUN) && !i_flush;
   assign compressed = is_compr(head0.hw);

   // Accept a word only when a full word of space is guaranteed, independent of the consumer
   assign o_fetch_ready = run_ok && (count <= 2'd1);

   // A faulting head is offered alone so the fault surfaces even without its second half
   assign o_instr_valid = run_ok && (count != 2'd0) &&
                          (compressed || head0.err || (count >= 2'd2));

   assign fetch_fire = o_fetch_ready && i_fetch_valid;
   assign instr_fire = o_instr_valid && i_instr_ready;

   assign o_instr          = compressed ? {16'b0, head0.hw} : {head1.hw, head0.hw};
   assign o_instr_pc       = head_pc;
   assign o_instr_is_compr = compressed;
   assign o_instr_err      = head0.err || (!compressed && (count >= 2'd2) && head1.err);

   // Decide how many halfwords leave and enter the queue this cycle
   always_comb begin
      pop_n       = 2'd0;
      push_n      = 2'd0;
      push_lo.hw  = skip ? i_fetch_data[31:16] : i_fetch_data[15:0];
      push_lo.err = i_fetch_err;
      push_hi.hw  = i_fetch_data[31:16];
      push_hi.err = i_fetch_err;
      if (instr_fire) begin
         if (compressed || (head0.err && (count == 2'd1))) begin
            pop_n = 2'd1;
         end else begin
            pop_n = 2'd2;
         end
      end
      if (fetch_fire) begin
         push_n = skip ? 2'd1 : 2'd2;
      end
   end

   // Run/halt control and the pending upper-halfword skip after a redirect
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= ST_RUN;
         skip  <= 1'b0;
      end else if (i_flush) begin
         state <= ST_RUN;
         skip  <= i_flush_pc[1];
      end else begin
         if (fetch_fire) begin
            skip <= 1'b0;
         end
         if (instr_fire && o_instr_err) begin
            state <= ST_HALT;
         end
      end
   end

   // Track the PC of the oldest buffered halfword; a push into an empty queue reloads it
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         head_pc <= '0;
      end else if (i_flush) begin
         head_pc <= i_flush_pc;
      end else if (fetch_fire && (count == pop_n)) begin
         head_pc <= skip ? (i_fetch_pc + PC_W'(2)) : i_fetch_pc;
      end else if (instr_fire) begin
         head_pc <= head_pc + ((pop_n == 2'd1) ? PC_W'(2) : PC_W'(4));
      end
   end

endmodule

// File: tb/tb_instr_realigner.sv
// Self-checking bench for instr_realigner.
// The reference model keeps a plain queue of halfwords, each tagged with its
// own address and fault bit, and derives every expected output from that.
module tb_instr_realigner;

   localparam int PC_W = 64;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_flush = 1'b0;
   logic [PC_W-1:0] i_flush_pc = '0;
   logic            i_fetch_valid = 1'b0;
   logic            o_fetch_ready;
   logic [31:0]     i_fetch_data = '0;
   logic [PC_W-1:0] i_fetch_pc = '0;
   logic            i_fetch_err = 1'b0;
   logic            o_instr_valid;
   logic            i_instr_ready = 1'b1;
   logic [31:0]     o_instr;
   logic [PC_W-1:0] o_instr_pc;
   logic            o_instr_is_compr;
   logic            o_instr_err;

   always #5 i_clk = ~i_clk;

   instr_realigner #(.PC_W(PC_W)) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_flush          (i_flush),
      .i_flush_pc       (i_flush_pc),
      .i_fetch_valid    (i_fetch_valid),
      .o_fetch_ready    (o_fetch_ready),
      .i_fetch_data     (i_fetch_data),
      .i_fetch_pc       (i_fetch_pc),
      .i_fetch_err      (i_fetch_err),
      .o_instr_valid    (o_instr_valid),
      .i_instr_ready    (i_instr_ready),
      .o_instr          (o_instr),
      .o_instr_pc       (o_instr_pc),
      .o_instr_is_compr (o_instr_is_compr),
      .o_instr_err      (o_instr_err)
   );

   typedef struct packed {
      logic [15:0]     hw;
      logic            err;
      logic [PC_W-1:0] pc;
   } mhw_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic            err;
   } seen_t;

   int testsRun = 0;
   int testsFailed = 0;

   mhw_t  mq[$];
   bit    mSkip = 1'b0;
   bit    mHalt = 1'b0;

   bit              eValid, eReady, eCompr, eErr, eInstrKnown, lastPush;
   logic [31:0]     eInstr;
   logic [PC_W-1:0] ePc;

   seen_t           seen[$];
   seen_t           expSeen[$];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic computeExpected();
      bit live;
      live        = i_rst_n && !mHalt && !i_flush;
      eReady      = live && (mq.size() <= 1);
      eValid      = 1'b0;
      eCompr      = 1'b0;
      eErr        = 1'b0;
      eInstrKnown = 1'b0;
      eInstr      = '0;
      ePc         = '0;
      if (mq.size() >= 1) begin
         eCompr = (mq[0].hw[1:0] != 2'b11);
         ePc    = mq[0].pc;
         eErr   = mq[0].err || (!eCompr && mq.size() >= 2 && mq[1].err);
         eValid = live && (eCompr || mq[0].err || mq.size() >= 2);
         if (eCompr) begin
            eInstr      = {16'h0000, mq[0].hw};
            eInstrKnown = 1'b1;
         end else if (mq.size() >= 2) begin
            eInstr      = {mq[1].hw, mq[0].hw};
            eInstrKnown = 1'b1;
         end
      end
   endtask

   task automatic updateModel();
      mhw_t e;
      int   n;
      lastPush = eReady && i_fetch_valid;
      if (!i_rst_n) begin
         mq.delete();
         mSkip = 1'b0;
         mHalt = 1'b0;
      end else if (i_flush) begin
         mq.delete();
         mHalt = 1'b0;
         mSkip = i_flush_pc[1];
      end else begin
         if (eValid && i_instr_ready) begin
            n = (eCompr || (mq[0].err && mq.size() == 1)) ? 1 : 2;
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            if (eErr) mHalt = 1'b1;
         end
         if (lastPush) begin
            if (!mSkip) begin
               e.hw = i_fetch_data[15:0]; e.err = i_fetch_err; e.pc = i_fetch_pc;
               mq.push_back(e);
            end
            e.hw = i_fetch_data[31:16]; e.err = i_fetch_err; e.pc = i_fetch_pc + 64'd2;
            mq.push_back(e);
            mSkip = 1'b0;
         end
      end
   endtask

   // One clock: check outputs against the model, advance the model at the edge
   task automatic applyStimulus();
      seen_t s;
      #1;
      computeExpected();
      checkOutput("fetch_ready", 64'(o_fetch_ready), 64'(eReady));
      checkOutput("instr_valid", 64'(o_instr_valid), 64'(eValid));
      if (eValid) begin
         if (eInstrKnown) checkOutput("instr", 64'(o_instr), 64'(eInstr));
         checkOutput("instr_pc", o_instr_pc, ePc);
         checkOutput("is_compr", 64'(o_instr_is_compr), 64'(eCompr));
         checkOutput("instr_err", 64'(o_instr_err), 64'(eErr));
      end
      if (o_instr_valid && i_instr_ready) begin
         s.instr = o_instr; s.pc = o_instr_pc; s.err = o_instr_err;
         seen.push_back(s);
      end
      @(posedge i_clk);
      updateModel();
      @(negedge i_clk);
   endtask

   task automatic pushWord(input logic [31:0] data, input logic [63:0] pc, input logic err);
      int tries;
      i_fetch_valid = 1'b1;
      i_fetch_data  = data;
      i_fetch_pc    = pc;
      i_fetch_err   = err;
      tries = 0;
      lastPush = 1'b0;
      while (!lastPush && tries < 20) begin
         applyStimulus();
         tries++;
      end
      i_fetch_valid = 1'b0;
      i_fetch_err   = 1'b0;
      if (!lastPush) checkOutput("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      i_fetch_valid = 1'b0;
      i_instr_ready = 1'b1;
      repeat (6) applyStimulus();
   endtask

   task automatic addExp(input logic [31:0] instr, input logic [63:0] pc, input logic err);
      seen_t s;
      s.instr = instr; s.pc = pc; s.err = err;
      expSeen.push_back(s);
   endtask

   task automatic checkSeen(input string tag);
      int n;
      checkOutput({tag, "_count"}, 64'(seen.size()), 64'(expSeen.size()));
      n = (seen.size() < expSeen.size()) ? seen.size() : expSeen.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_instr"}, 64'(seen[i].instr), 64'(expSeen[i].instr));
         checkOutput({tag, "_pc"}, seen[i].pc, expSeen[i].pc);
         checkOutput({tag, "_err"}, 64'(seen[i].err), 64'(expSeen[i].err));
      end
      seen.delete();
      expSeen.delete();
   endtask

   initial begin
      logic [63:0] nextPc;
      logic [63:0] fp;

      // Reset
      i_rst_n = 1'b0;
      repeat (2) applyStimulus();
      i_rst_n = 1'b1;
      #1;
      checkOutput("post_reset_fready", 64'(o_fetch_ready), 64'd1);
      checkOutput("post_reset_valid", 64'(o_instr_valid), 64'd0);
      checkOutput("post_reset_pc", o_instr_pc, 64'd0);

      // Single 32-bit instruction, valid the cycle after acceptance
      pushWord(32'h00A00513, 64'h1000, 1'b0);
      checkOutput("t1_latency", 64'(o_instr_valid), 64'd1);
      checkOutput("t1_instr", 64'(o_instr), 64'h00A00513);
      drain();
      checkOutput("t1_empty", 64'(o_instr_valid), 64'd0);
      addExp(32'h00A00513, 64'h1000, 1'b0);
      checkSeen("t1");

      // Two compressed instructions in one word
      pushWord(32'h45854505, 64'h1000, 1'b0);
      checkOutput("t2_first", 64'(o_instr), 64'h00004505);
      applyStimulus();
      checkOutput("t2_second", 64'(o_instr), 64'h00004585);
      checkOutput("t2_second_pc", o_instr_pc, 64'h1002);
      drain();
      addExp(32'h00004505, 64'h1000, 1'b0);
      addExp(32'h00004585, 64'h1002, 1'b0);
      checkSeen("t2");

      // Straddling 32-bit instruction
      pushWord(32'h05134505, 64'h1000, 1'b0);
      pushWord(32'h458500A0, 64'h1004, 1'b0);
      drain();
      addExp(32'h00004505, 64'h1000, 1'b0);
      addExp(32'h00A00513, 64'h1002, 1'b0);
      addExp(32'h00004585, 64'h1006, 1'b0);
      checkSeen("t3");

      // Redirect to an upper halfword discards buffered data and the lower half
      i_instr_ready = 1'b0;
      pushWord(32'h45854505, 64'h1000, 1'b0);
      i_flush = 1'b1;
      i_flush_pc = 64'h2002;
      #1;
      checkOutput("t4_flush_fready", 64'(o_fetch_ready), 64'd0);
      checkOutput("t4_flush_valid", 64'(o_instr_valid), 64'd0);
      applyStimulus();
      i_flush = 1'b0;
      i_instr_ready = 1'b1;
      pushWord(32'h45050001, 64'h2000, 1'b0);
      drain();
      addExp(32'h00004505, 64'h2002, 1'b0);
      checkSeen("t4");

      // Backpressure
      i_instr_ready = 1'b0;
      pushWord(32'h00A00513, 64'h5000, 1'b0);
      i_fetch_valid = 1'b1;
      i_fetch_data  = 32'h45854505;
      i_fetch_pc    = 64'h5004;
      repeat (3) begin
         applyStimulus();
         checkOutput("t5_fready_low", 64'(o_fetch_ready), 64'd0);
         checkOutput("t5_hold_instr", 64'(o_instr), 64'h00A00513);
         checkOutput("t5_hold_pc", o_instr_pc, 64'h5000);
      end
      i_instr_ready = 1'b1;
      pushWord(32'h45854505, 64'h5004, 1'b0);
      drain();
      addExp(32'h00A00513, 64'h5000, 1'b0);
      addExp(32'h00004505, 64'h5004, 1'b0);
      addExp(32'h00004585, 64'h5006, 1'b0);
      checkSeen("t5");

      // Fetch fault halts the stream until a redirect
      pushWord(32'h00A00513, 64'h3000, 1'b1);
      checkOutput("t6_err_valid", 64'(o_instr_valid), 64'd1);
      checkOutput("t6_err_flag", 64'(o_instr_err), 64'd1);
      i_fetch_valid = 1'b1;
      i_fetch_data  = 32'h45854505;
      i_fetch_pc    = 64'h3004;
      repeat (4) begin
         applyStimulus();
         checkOutput("t6_halt_valid", 64'(o_instr_valid), 64'd0);
         checkOutput("t6_halt_fready", 64'(o_fetch_ready), 64'd0);
      end
      i_fetch_valid = 1'b0;
      i_flush = 1'b1;
      i_flush_pc = 64'h4000;
      applyStimulus();
      i_flush = 1'b0;
      pushWord(32'h00A00513, 64'h4000, 1'b0);
      drain();
      addExp(32'h00A00513, 64'h3000, 1'b1);
      addExp(32'h00A00513, 64'h4000, 1'b0);
      checkSeen("t6");

      // Reset in the middle of a straddling instruction
      pushWord(32'h05134505, 64'h6000, 1'b0);
      applyStimulus();
      i_rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_valid", 64'(o_instr_valid), 64'd0);
      checkOutput("rst_mid_fready", 64'(o_fetch_ready), 64'd0);
      applyStimulus();
      i_rst_n = 1'b1;
      #1;
      checkOutput("rst_after_valid", 64'(o_instr_valid), 64'd0);
      checkOutput("rst_after_fready", 64'(o_fetch_ready), 64'd1);
      checkOutput("rst_after_pc", o_instr_pc, 64'd0);
      drain();
      addExp(32'h00004505, 64'h6000, 1'b0);
      checkSeen("rst_mid");

      // Randomized traffic with redirects, faults and stalls
      nextPc = 64'h8000;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         i_rst_n       = ($urandom_range(999) != 0);
         i_flush       = mHalt ? ($urandom_range(4) == 0) : ($urandom_range(49) == 0);
         fp            = {32'h0, $urandom} & 64'h0000_0000_0000_FFFE;
         i_flush_pc    = fp;
         i_fetch_valid = ($urandom_range(9) < 7);
         i_fetch_data  = $urandom;
         i_fetch_pc    = nextPc;
         i_fetch_err   = ($urandom_range(59) == 0);
         i_instr_ready = ($urandom_range(9) < 7);
         applyStimulus();
         if (!i_rst_n) nextPc = 64'h8000;
         else if (i_flush) nextPc = fp & ~64'h3;
         else if (lastPush) nextPc = nextPc + 64'd4;
      end
      i_rst_n = 1'b1;
      i_flush = 1'b0;
      i_fetch_err = 1'b0;
      drain();
      seen.delete();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
